// File: rtl/btn_arb_pkg.sv
// Shared defaults, width helpers and grant FSM state type for the button event arbiter.
package btn_arb_pkg;

    localparam int unsigned NUM_BTN_DEF = 4;
    localparam int unsigned HOLDOFF_DEF = 16;

    // Index width for a given button count, never narrower than one bit.
    function automatic int unsigned id_w(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

    // Holdoff counter width able to hold the value h.
    function automatic int unsigned cnt_w(input int unsigned h);
        return (h > 0) ? int'($clog2(h + 1)) : 1;
    endfunction

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/btn_press_det.sv
// Per-button front end: synchronizer, history flop, falling-edge detect and holdoff.
// o_press_c is a single-cycle strobe for each accepted press.
module btn_press_det
    import btn_arb_pkg::*;
#(
    parameter int unsigned HOLDOFF = HOLDOFF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_n,
    output logic o_press_c
);

    localparam int unsigned CNT_W = cnt_w(HOLDOFF);

    logic             r_s1;
    logic             r_s2;
    logic             r_s3;
    logic [CNT_W-1:0] r_holdoff;
    logic             w_fall;

    // Released-to-pressed transition seen on the synchronized level.
    assign w_fall    = r_s3 & ~r_s2;
    assign o_press_c = w_fall && (r_holdoff == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= i_btn_n;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_holdoff <= '0;
        end else if (o_press_c) begin
            r_holdoff <= CNT_W'(HOLDOFF);
        end else if (r_holdoff != '0) begin
            r_holdoff <= r_holdoff - CNT_W'(1);
        end
    end

endmodule

// File: rtl/button_event_arbiter.sv
// Collects debounced button presses, arbitrates them round-robin and presents
// one event at a time on a valid/ready port with a sticky lost-press flag.
module button_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter  int unsigned NUM_BTN = NUM_BTN_DEF,
    parameter  int unsigned HOLDOFF = HOLDOFF_DEF,
    localparam int unsigned ID_W    = id_w(NUM_BTN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_n,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [ID_W-1:0]    ev_id,
    output logic               ev_overflow,
    input  logic               clr_ovf
);

    arb_state_e         r_state;
    arb_state_e         w_state_nxt;
    logic [NUM_BTN-1:0] r_pending;
    logic [NUM_BTN-1:0] w_pending_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_ev_id;
    logic               r_ovf;
    logic [NUM_BTN-1:0] w_press;
    logic [NUM_BTN-1:0] w_grant_vec;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_found;
    logic               w_load;
    logic               w_ovf_set;

    // (base + off) mod NUM_BTN, valid for base < NUM_BTN and off <= NUM_BTN.
    function automatic logic [ID_W-1:0] wrap_idx(input int unsigned base, input int unsigned off);
        int unsigned s;
        s = base + off;
        if (s >= NUM_BTN) begin
            s = s - NUM_BTN;
        end
        return ID_W'(s);
    endfunction

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_det
        btn_press_det #(
            .HOLDOFF (HOLDOFF)
        ) u_det (
            .clk       (clk),
            .rst       (rst),
            .i_btn_n   (btn_n[g]),
            .o_press_c (w_press[g])
        );
    end

    // Round-robin search: first pending index at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int unsigned k = 0; k < NUM_BTN; k++) begin
            if (!w_found && r_pending[wrap_idx(32'(r_rr_ptr), k)]) begin
                w_found     = 1'b1;
                w_grant_idx = wrap_idx(32'(r_rr_ptr), k);
            end
        end
    end

    assign w_load        = ((r_state == IDLE) || ev_ready) && w_found;
    assign w_grant_vec   = w_load ? (NUM_BTN'(1) << w_grant_idx) : '0;
    assign w_pending_nxt = (r_pending & ~w_grant_vec) | w_press;
    // A press on a button still waiting (and not leaving this cycle) is lost.
    assign w_ovf_set     = |(w_press & r_pending & ~w_grant_vec);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_load) begin
                    w_state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (ev_ready && !w_found) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ev_id   <= '0;
            r_rr_ptr  <= '0;
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            if (w_load) begin
                r_ev_id  <= w_grant_idx;
                r_rr_ptr <= wrap_idx(32'(w_grant_idx), 1);
            end
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign ev_valid    = (r_state == PRESENT);
    assign ev_id       = r_ev_id;
    assign ev_overflow = r_ovf;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter: expected event ids are queued as
// presses are issued and a monitor pops and compares them on every transfer.
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_n;
    logic       ev_ready;
    logic       clr_ovf;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_overflow;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    button_event_arbiter #(
        .NUM_BTN (4),
        .HOLDOFF (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_n       (btn_n),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_id       (ev_id),
        .ev_overflow (ev_overflow),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int k;
        k = 0;
        while (!ev_valid && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        chk(name, int'(ev_valid), 1);
    endtask

    // Two buttons fell together; expect id a at E3 then id b at E4 (ready high).
    task automatic expect_pair(input string name, input int a, input int b);
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk({name, "_valid0"}, int'(ev_valid), 1);
                chk({name, "_id0"}, int'(ev_id), a);
            end else if (k == 4) begin
                chk({name, "_valid1"}, int'(ev_valid), 1);
                chk({name, "_id1"}, int'(ev_id), b);
            end else if (k == 5) begin
                chk({name, "_idle"}, int'(ev_valid), 0);
            end
        end
    endtask

    // Monitor: every completed transfer must match the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && ev_valid && ev_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_event: got id %0d expected none at %0t", ev_id, $time);
                end else begin
                    chk("event_id", int'(ev_id), exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        btn_n    = 4'hF;
        ev_ready = 1'b0;
        clr_ovf  = 1'b0;
        #2;
        chk("reset_valid", int'(ev_valid), 0);
        chk("reset_id", int'(ev_id), 0);
        chk("reset_ovf", int'(ev_overflow), 0);
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Single press on button 2: visible at E3 for exactly one cycle.
        ev_ready = 1'b1;
        btn_n[2] = 1'b0;
        exp_q.push_back(2);
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("single_valid", int'(ev_valid), (k == 3) ? 1 : 0);
            if (k == 3) begin
                chk("single_id", int'(ev_id), 2);
            end
        end
        cyc(1);
        btn_n[2] = 1'b1;
        cyc(25);

        // Bring rr_ptr to 0 by granting button 3, then a simultaneous 0/3 press.
        btn_n[3] = 1'b0;
        exp_q.push_back(3);
        cyc(4);
        btn_n[3] = 1'b1;
        cyc(25);
        btn_n[0] = 1'b0;
        btn_n[3] = 1'b0;
        exp_q.push_back(0);
        exp_q.push_back(3);
        expect_pair("fair_rr0", 0, 3);
        cyc(1);
        btn_n = 4'hF;
        cyc(25);

        // Grant button 0 alone so rr_ptr becomes 1, then repeat the pair.
        btn_n[0] = 1'b0;
        exp_q.push_back(0);
        cyc(4);
        btn_n[0] = 1'b1;
        cyc(25);
        btn_n[0] = 1'b0;
        btn_n[3] = 1'b0;
        exp_q.push_back(3);
        exp_q.push_back(0);
        expect_pair("fair_rr1", 3, 0);
        cyc(1);
        btn_n = 4'hF;
        cyc(25);

        // Backpressure on button 1: held output, one pending, then a lost press.
        ev_ready = 1'b0;
        btn_n[1] = 1'b0;
        exp_q.push_back(1);
        wait_valid("bp_first_valid", 8);
        cyc(1);
        btn_n[1] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", int'(ev_valid), 1);
            chk("bp_hold_id", int'(ev_id), 1);
        end
        cyc(10);
        btn_n[1] = 1'b0;
        exp_q.push_back(1);
        cyc(4);
        btn_n[1] = 1'b1;
        cyc(2);
        chk("bp_second_ovf", int'(ev_overflow), 0);
        chk("bp_second_id", int'(ev_id), 1);
        cyc(20);
        btn_n[1] = 1'b0;
        cyc(4);
        btn_n[1] = 1'b1;
        cyc(2);
        chk("bp_third_ovf", int'(ev_overflow), 1);
        chk("bp_third_valid", int'(ev_valid), 1);
        cyc(20);

        // Overflow clear in the same cycle as a new lost press: set wins.
        btn_n[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        @(negedge clk);
        chk("clr_with_set_ovf", int'(ev_overflow), 1);
        cyc(3);
        btn_n[1] = 1'b1;
        cyc(3);
        chk("ovf_sticky", int'(ev_overflow), 1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        @(negedge clk);
        chk("clr_alone_ovf", int'(ev_overflow), 0);
        cyc(1);
        ev_ready = 1'b1;
        cyc(5);
        chk("bp_drained_valid", int'(ev_valid), 0);
        cyc(20);

        // Bouncing button 2 inside its holdoff window yields a single event.
        exp_q.push_back(2);
        for (int p = 0; p < 3; p++) begin
            btn_n[2] = 1'b0;
            cyc(2);
            btn_n[2] = 1'b1;
            cyc(2);
        end
        cyc(30);
        chk("holdoff_ovf", int'(ev_overflow), 0);
        chk("holdoff_q_empty", exp_q.size(), 0);

        // Reset while presenting id 3 with buttons 0 and 1 still pending.
        ev_ready = 1'b0;
        btn_n    = 4'b0100;
        wait_valid("rst_mid_valid", 8);
        cyc(1);
        @(negedge clk);
        chk("rst_mid_id", int'(ev_id), 3);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", int'(ev_valid), 0);
        chk("rst_async_id", int'(ev_id), 0);
        chk("rst_async_ovf", int'(ev_overflow), 0);
        btn_n = 4'hF;
        cyc(2);
        rst      = 1'b0;
        ev_ready = 1'b1;
        cyc(30);
        chk("post_rst_idle", int'(ev_valid), 0);

        // Button 1 held low across reset release gives exactly one event.
        rst      = 1'b1;
        btn_n[1] = 1'b0;
        cyc(2);
        rst = 1'b0;
        exp_q.push_back(1);
        cyc(10);
        btn_n[1] = 1'b1;
        cyc(30);

        chk("final_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
